if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
Instruction-fetch front end that replaces the bare PC-register / instruction-memory path feeding the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to an instruction memory with variable response latency.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO and presents them to IF/ID under a valid/ready handshake.
- Accepts a redirect (taken branch from MEM) that flushes the queue and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the maximum number of outstanding memory requests (power of two, at least 2)
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
ADDR_W, 32, PC/address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
imem_req  out  1  request valid; the memory always accepts it
imem_addr  out  ADDR_W  request address (current fetch PC)
imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after the request
imem_rdata  in  32  response instruction word
redirect_valid  in  1  flush and redirect (PCSrc)
redirect_pc  in  ADDR_W  redirect target
out_valid  out  1  queue head valid
out_instr  out  32  head instruction
out_pc4  out  ADDR_W  head PC+4
out_ready  in  1  IF/ID accepts the head this cycle

Behaviour:
- Reset: all state is updated on the CLK edge while RST==0.
  - fetch_pc=RESET_PC; count=0; inflight=0; drop_cnt=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc4=0.
  - Reset asserted mid-operation discards everything. Responses to pre-reset requests are the memory's responsibility; the memory is reset by the same RST.
- State:
  - fetch_pc.
  - FIFO of {pc4, instr} with count 0..DEPTH.
  - inflight, 0..DEPTH: all outstanding requests.
  - drop_cnt, 0..inflight: stale outstanding requests.
- Issue: imem_req=1 iff all of the following hold:
  - redirect_valid==0;
  - inflight<DEPTH;
  - count+(inflight-drop_cnt)<DEPTH, so every live request has a guaranteed slot.
- Issue effects (combinational request, registered updates):
  - imem_addr=fetch_pc.
  - On issue: fetch_pc+=4, wrapping mod 2^ADDR_W.
  - Each request tags its pc4 = issued address + 4, held in a DEPTH-entry tag ring alongside the request stream.
- Response (imem_rvalid):
  - inflight decrements.
  - If drop_cnt>0: drop_cnt decrements and the data is discarded.
  - Otherwise {tag pc4, imem_rdata} is enqueued.
- Pop: the head is dequeued when out_valid && out_ready && !redirect_valid.
- Output: out_valid=(count!=0), driven from registered FIFO storage, so there is no combinational path from imem_rdata.
- Latency: request in cycle t, response in cycle t+L, out_valid visible in cycle t+L+1.
- Redirect (has priority over everything):
  - count:=0; fetch_pc:=redirect_pc; no request and no pop that cycle.
  - drop_cnt := inflight after counting any same-cycle response. A same-cycle response is discarded.
  - Requests resume from redirect_pc in the next cycle.
  - Back-to-back redirects: each one overrides the previous; drop_cnt accumulates all remaining inflight.
- Simultaneous enqueue and pop when full: both proceed and count is unchanged. Issue uses the pre-update count, so it is conservative and never overflows.
- Full with out_ready=0: outputs hold stable, no new requests issue, and in-flight responses still fit by construction.
- Empty with out_ready=1: nothing happens; out_valid stays 0.
- Assertions:
  - No enqueue while count==DEPTH.
  - imem_rvalid never arrives with inflight==0.

Decomposition:
- Shared package if_pkg:
  - DEPTH and RESET_PC defaults.
  - The fetch entry struct {pc4[ADDR_W-1:0], instr[31:0]}.
  - PC_STEP=4.
- Sub-module fetch_fifo: synchronous FIFO parameterised by width and depth.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Instantiated for the instruction queue; the pc4 tag ring is a second instance or shared logic.
- The top level holds fetch_pc, inflight/drop_cnt accounting and issue logic.

Test Plan:
1. Reset, L=1 memory, out_ready=1:
   - Requests go to 0,4,8,…
   - First out_valid in the 3rd cycle after release with out_pc4=4; afterwards one instruction per cycle.
2. out_ready=0 with L=2:
   - Exactly 4 requests issue (0x0–0xC), then imem_req=0.
   - count=4; head holds instr@0, pc4=4.
   - Raising out_ready resumes requests at 0x10.
3. Redirect to 0x100 with 3 requests in flight at L=3:
   - Those 3 responses are dropped and never appear on the outputs.
   - The next request is to 0x100; the first output after it has out_pc4=0x104.
4. Redirect in the same cycle as imem_rvalid and out_ready=1:
   - The response is discarded, no pop occurs, and out_valid=0 the next cycle.
5. fetch_pc=32'hFFFF_FFFC:
   - The next request is to 0x0 and the entry has out_pc4=0.
6. Assert RST low for one cycle mid-stream with the queue full:
   - The next cycle shows out_valid=0, imem_req=0, imem_addr=RESET_PC.
   - Fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
package if_pkg;

    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_STEP      = 4;

    // Queue entry layout: pc4 in the upper bits, instruction word below.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc4;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage and flush; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: owns the fetch PC, keeps requests in flight to instruction
// memory, buffers {pc4, instr} entries and hands them to IF/ID under valid/ready.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int unsigned         DEPTH    = DEF_DEPTH,
    parameter int unsigned         ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc4,
    input  logic              out_ready
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   live;
    logic [OCC_W-1:0]   occupancy;
    logic               issue;
    logic               enq;
    logic               pop;
    logic               q_full;
    logic               q_empty;
    logic               tag_full;
    logic               tag_empty;
    logic [ADDR_W-1:0]  tag_pc4;
    logic [ENTRY_W-1:0] q_head;

    // Issue only when every live request already owns a free queue slot.
    always_comb begin
        live      = inflight - drop_cnt;
        occupancy = OCC_W'(count) + OCC_W'(live);
        issue     = RST && !redirect_valid && !tag_full && (occupancy < OCC_W'(DEPTH));
        enq       = imem_rvalid && !redirect_valid && (drop_cnt == '0);
        pop       = !q_empty && out_ready && !redirect_valid;
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign out_valid = !q_empty;
    assign out_pc4   = q_head[ENTRY_W-1:INSTR_W];
    assign out_instr = q_head[INSTR_W-1:0];

    // Fetch PC and count of stale responses still to be discarded.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            drop_cnt <= inflight - CNT_W'(imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
            if (imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Tag ring: one pc4 per outstanding request; its occupancy is the in-flight count.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_ring (
        .clk   (CLK),
        .rst_n (RST),
        .push  (issue),
        .pop   (imem_rvalid),
        .flush (1'b0),
        .wdata (fetch_pc + ADDR_W'(PC_STEP)),
        .rdata (tag_pc4),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    // Instruction queue presented to IF/ID; redirect flushes it.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (CLK),
        .rst_n (RST),
        .push  (enq),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({tag_pc4, imem_rdata}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (count)
    );

    // Slot reservation at issue time must make these unreachable.
    a_no_overflow : assert property (@(posedge CLK) disable iff (!RST) !(enq && q_full));
    a_rsp_expected : assert property (@(posedge CLK) disable iff (!RST) !(imem_rvalid && tag_empty));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with an in-order fixed-latency memory model.
module tb_if_prefetch_queue;
    import if_pkg::*;

    logic        CLK;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;
    mreq_t mq[$];

    typedef struct {
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
    } vec_t;
    vec_t tv[10];

    if_prefetch_queue dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4),
        .out_ready      (out_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare the queue head against an entry built from the expected pc4.
    task automatic chk_head(input string name, input logic [31:0] pc4);
        fetch_entry_t e;
        e.pc4   = pc4;
        e.instr = instr_of(pc4 - 32'd4);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".pc4"}, out_pc4, e.pc4);
        chk({name, ".instr"}, out_instr, e.instr);
    endtask

    // One clock: sample the request mid-cycle, then update the memory model after the edge.
    task automatic tick();
        logic        s_req;
        logic        s_rst;
        logic [31:0] s_addr;
        mreq_t       r;
        @(negedge CLK);
        s_req  = imem_req;
        s_addr = imem_addr;
        s_rst  = RST;
        @(posedge CLK);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!s_rst) begin
            mq.delete();
        end else begin
            if (s_req) begin
                r.due  = cyc - 1 + lat;
                r.addr = s_addr;
                mq.push_back(r);
                n_req++;
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    endtask

    task automatic chk_reset_state(input string name);
        #1;
        chk({name, ".req"}, 32'(imem_req), 32'd0);
        chk({name, ".addr"}, imem_addr, 32'h0000_0000);
        chk({name, ".valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset(input int l);
        lat            = l;
        RST            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        chk_reset_state("rst");
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.pc4", out_pc4, 32'd0);
        tick();
        RST   = 1'b1;
        n_req = 0;
    endtask

    initial begin
        RST            = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Streaming at L=1, then a short stall and resume.
        tv[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tv[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tv[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tv[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        tv[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        tv[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
        tv[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
        tv[7] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
        tv[8] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
        tv[9] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18};

        out_ready = 1'b1;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            out_ready = tv[i].rdy;
            #1;
            chk($sformatf("t1[%0d].req", i), 32'(imem_req), 32'(tv[i].e_req));
            chk($sformatf("t1[%0d].addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("t1[%0d].valid", i), 32'(out_valid), 32'(tv[i].e_valid));
            if (tv[i].e_valid) begin
                chk($sformatf("t1[%0d].pc4", i), out_pc4, tv[i].e_pc4);
                chk($sformatf("t1[%0d].instr", i), out_instr, instr_of(tv[i].e_pc4 - 32'd4));
            end
            tick();
        end

        // Back-pressure at L=2: exactly DEPTH requests, then hold, then resume at 0x10.
        out_ready = 1'b0;
        do_reset(2);
        repeat (10) tick();
        #1;
        chk("t2.nreq", 32'(n_req), 32'd4);
        chk("t2.req", 32'(imem_req), 32'd0);
        chk("t2.addr", imem_addr, 32'h10);
        chk_head("t2.head", 32'h04);
        repeat (3) tick();
        #1;
        chk_head("t2.hold", 32'h04);
        chk("t2.hold_req", 32'(imem_req), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_head($sformatf("t2.drain%0d", i), 32'(4 * (i + 1)));
            if (i == 0) chk("t2.req_full", 32'(imem_req), 32'd0);
            if (i == 1) begin
                chk("t2.req_resume", 32'(imem_req), 32'd1);
                chk("t2.addr_resume", imem_addr, 32'h10);
            end
            tick();
        end

        // Redirect to 0x100 with three requests outstanding at L=3.
        out_ready = 1'b1;
        do_reset(3);
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("t3.c%0d.valid", i), 32'(out_valid), 32'd0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3.redir_req", 32'(imem_req), 32'd0);
        chk("t3.redir_rvalid_bench", 32'(imem_rvalid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3.req", 32'(imem_req), 32'd1);
        chk("t3.addr", imem_addr, 32'h100);
        for (int i = 5; i <= 8; i++) begin
            #1;
            chk($sformatf("t3.c%0d.valid", i), 32'(out_valid), 32'd0);
            tick();
        end
        #1;
        chk_head("t3.first", 32'h104);

        // Redirect coinciding with a response while the head is being accepted.
        out_ready = 1'b1;
        do_reset(1);
        repeat (3) tick();
        #1;
        chk_head("t4.pre", 32'h08);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        chk("t4.redir_req", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4.valid", 32'(out_valid), 32'd0);
        chk("t4.req", 32'(imem_req), 32'd1);
        chk("t4.addr", imem_addr, 32'h200);
        repeat (2) tick();
        #1;
        chk_head("t4.first", 32'h204);

        // Fetch PC wrap at the top of the address space.
        out_ready = 1'b1;
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5.addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        chk("t5.addr_wrap", imem_addr, 32'h0000_0000);
        chk("t5.req_wrap", 32'(imem_req), 32'd1);
        tick();
        #1;
        chk_head("t5.head_wrap", 32'h0000_0000);
        tick();
        #1;
        chk_head("t5.head_next", 32'h0000_0004);

        // One-cycle reset with the queue full, then restart from RESET_PC.
        out_ready = 1'b0;
        do_reset(2);
        repeat (10) tick();
        #1;
        chk_head("t6.full", 32'h04);
        RST = 1'b0;
        tick();
        chk_reset_state("t6.rst");
        RST       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t6.req", 32'(imem_req), 32'd1);
        chk("t6.addr", imem_addr, 32'h0000_0000);
        repeat (3) tick();
        #1;
        chk_head("t6.first", 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
